// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, defaults and saturating adder for the vending controller
package vend_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFUND = 1'b1
    } state_t;

    // Working width for credit arithmetic, wide enough for any sensible MONEY_W
    localparam int CALC_W = 32;

    localparam logic [7:0]  DEF_COIN_VAL   = {4'd2, 4'd1};
    localparam logic [15:0] DEF_ITEM_PRICE = {4'd5, 4'd3, 4'd2, 4'd1};

    typedef struct packed {
        logic [CALC_W-1:0] value;
        logic              clip;
    } sat_t;

    // Add and clamp to the largest credit representable in money_w bits
    function automatic sat_t sat_add(input logic [CALC_W-1:0] a,
                                     input logic [CALC_W-1:0] b,
                                     input int                money_w);
        logic [CALC_W-1:0] max_val;
        logic [CALC_W-1:0] sum;
        sat_t              res;
        max_val = (CALC_W'(1) << money_w) - CALC_W'(1);
        sum     = a + b;
        if (sum > max_val) begin
            res.value = max_val;
            res.clip  = 1'b1;
        end else begin
            res.value = sum;
            res.clip  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/vend_ctrl_param_if.sv
// rtl/vend_ctrl_param_if.sv - coin/buy/refund bus between front-end filters and the controller
interface vend_ctrl_param_if #(
    parameter int NUM_COINS = 2,
    parameter int NUM_ITEMS = 4,
    parameter int MONEY_W   = 4
);
    localparam int TYPE_W = $clog2(NUM_ITEMS);

    logic [NUM_COINS-1:0] coin;
    logic                 buy;
    logic [TYPE_W-1:0]    buy_type;
    logic                 clr;
    logic [MONEY_W-1:0]   money_left;
    logic [TYPE_W-1:0]    bought_type;
    logic                 bought_valid;
    logic                 deny;
    logic                 coin_reject;
    logic                 change_valid;
    logic                 change_ready;

    modport master (
        output coin, buy, buy_type, clr, change_ready,
        input  money_left, bought_type, bought_valid, deny, coin_reject, change_valid
    );

    modport slave (
        input  coin, buy, buy_type, clr, change_ready,
        output money_left, bought_type, bought_valid, deny, coin_reject, change_valid
    );

endinterface

// File: rtl/vend_coin_sum.sv
// rtl/vend_coin_sum.sv - combinational total value of all coins asserted this cycle
module vend_coin_sum #(
    parameter int                           NUM_COINS = 2,
    parameter int                           MONEY_W   = 4,
    parameter int                           CSUM_W    = MONEY_W + $clog2(NUM_COINS),
    parameter logic [NUM_COINS*MONEY_W-1:0] COIN_VAL  = vend_pkg::DEF_COIN_VAL
) (
    input  logic [NUM_COINS-1:0] coin,
    output logic [CSUM_W-1:0]    csum
);

    // Widened so simultaneous coins of maximum value cannot wrap
    always_comb begin
        csum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin[i]) begin
                csum = csum + CSUM_W'(COIN_VAL[i*MONEY_W +: MONEY_W]);
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised coin counter with purchase grant and unit-wise refund
module vend_ctrl_param
    import vend_pkg::*;
#(
    parameter int                           NUM_COINS  = 2,
    parameter int                           NUM_ITEMS  = 4,
    parameter int                           MONEY_W    = 4,
    parameter logic [NUM_COINS*MONEY_W-1:0] COIN_VAL   = DEF_COIN_VAL,
    parameter logic [NUM_ITEMS*MONEY_W-1:0] ITEM_PRICE = DEF_ITEM_PRICE
) (
    input  logic               clk,
    input  logic               rst,
    vend_ctrl_param_if.slave   bus
);

    localparam int TYPE_W = $clog2(NUM_ITEMS);
    localparam int CSUM_W = MONEY_W + $clog2(NUM_COINS);

    state_t               state;
    logic [MONEY_W-1:0]   money_left;
    logic [TYPE_W-1:0]    bought_type;
    logic                 bought_valid;
    logic                 deny;
    logic                 coin_reject;
    logic                 change_valid;

    logic [CSUM_W-1:0]    csum;
    logic [MONEY_W-1:0]   price;
    logic                 type_ok;
    logic                 can_buy;
    sat_t                 add_res;
    sat_t                 buy_res;

    vend_coin_sum #(
        .NUM_COINS (NUM_COINS),
        .MONEY_W   (MONEY_W),
        .CSUM_W    (CSUM_W),
        .COIN_VAL  (COIN_VAL)
    ) u_coin_sum (
        .coin (bus.coin),
        .csum (csum)
    );

    // Price lookup; an unmatched select leaves type_ok low so the buy is refused
    always_comb begin
        price   = '0;
        type_ok = 1'b0;
        for (int j = 0; j < NUM_ITEMS; j++) begin
            if (TYPE_W'(j) == bus.buy_type) begin
                price   = ITEM_PRICE[j*MONEY_W +: MONEY_W];
                type_ok = 1'b1;
            end
        end
    end

    // Candidate credit updates; only registered credit funds a purchase
    always_comb begin
        can_buy = type_ok && (money_left >= price);
        add_res = sat_add(CALC_W'(money_left), CALC_W'(csum), MONEY_W);
        buy_res = sat_add(CALC_W'(money_left) - CALC_W'(price), CALC_W'(csum), MONEY_W);
    end

    // Controller FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            money_left   <= '0;
            bought_type  <= '0;
            bought_valid <= 1'b0;
            deny         <= 1'b0;
            coin_reject  <= 1'b0;
            change_valid <= 1'b0;
        end else begin
            deny        <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.clr) begin
                        money_left   <= add_res.value[MONEY_W-1:0];
                        coin_reject  <= add_res.clip;
                        bought_valid <= 1'b0;
                        change_valid <= (add_res.value != '0);
                        state        <= REFUND;
                    end else if (bus.buy && can_buy) begin
                        money_left   <= buy_res.value[MONEY_W-1:0];
                        coin_reject  <= buy_res.clip;
                        bought_type  <= bus.buy_type;
                        bought_valid <= 1'b1;
                    end else begin
                        money_left  <= add_res.value[MONEY_W-1:0];
                        coin_reject <= add_res.clip;
                        if (bus.buy) begin
                            deny         <= 1'b1;
                            bought_valid <= 1'b0;
                        end
                    end
                end
                REFUND: begin
                    coin_reject <= |bus.coin;
                    deny        <= bus.buy;
                    if (money_left == '0) begin
                        change_valid <= 1'b0;
                        state        <= IDLE;
                    end else if (change_valid && bus.change_ready) begin
                        money_left <= money_left - MONEY_W'(1);
                        if (money_left == MONEY_W'(1)) begin
                            change_valid <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.money_left   = money_left;
    assign bus.bought_type  = bought_type;
    assign bus.bought_valid = bought_valid;
    assign bus.deny         = deny;
    assign bus.coin_reject  = coin_reject;
    assign bus.change_valid = change_valid;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - directed self-checking bench for vend_ctrl_param
module tb_vend_ctrl_param;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vend_ctrl_param_if #(.NUM_COINS(2), .NUM_ITEMS(4), .MONEY_W(4)) bus ();

    vend_ctrl_param #(
        .NUM_COINS  (2),
        .NUM_ITEMS  (4),
        .MONEY_W    (4),
        .COIN_VAL   ({4'd2, 4'd1}),
        .ITEM_PRICE ({4'd5, 4'd3, 4'd2, 4'd1})
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs, then settle just after the edge
    task automatic step(input logic [1:0] c, input logic b, input logic [1:0] t, input logic cl);
        bus.coin     = c;
        bus.buy      = b;
        bus.buy_type = t;
        bus.clr      = cl;
        @(posedge clk);
        #1;
        bus.coin = 2'b00;
        bus.buy  = 1'b0;
        bus.clr  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.money_left !== 4'd0 || bus.bought_type !== 2'd0 || bus.bought_valid !== 1'b0 ||
            bus.deny !== 1'b0 || bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0) begin
            $display("FAIL reset: money=%0d type=%0d bv=%b deny=%b rej=%b cv=%b, required all zero",
                     bus.money_left, bus.bought_type, bus.bought_valid, bus.deny, bus.coin_reject, bus.change_valid);
            errors++;
        end
    endtask

    task automatic test_coins();
        logic [1:0] cin [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
        logic [3:0] exp [4] = '{4'd1, 4'd2, 4'd3, 4'd5};
        for (int i = 0; i < 4; i++) begin
            step(cin[i], 1'b0, 2'd0, 1'b0);
            checks++;
            if (bus.money_left !== exp[i] || bus.deny !== 1'b0 || bus.coin_reject !== 1'b0) begin
                $display("FAIL coins[%0d]: money=%0d deny=%b rej=%b, required money=%0d deny=0 rej=0",
                         i, bus.money_left, bus.deny, bus.coin_reject, exp[i]);
                errors++;
            end
        end
    endtask

    task automatic test_buy();
        step(2'b00, 1'b1, 2'd3, 1'b0);
        checks++;
        if (bus.money_left !== 4'd0 || bus.bought_type !== 2'd3 || bus.bought_valid !== 1'b1 || bus.deny !== 1'b0) begin
            $display("FAIL buy_grant: money=%0d type=%0d bv=%b deny=%b, required 0 3 1 0",
                     bus.money_left, bus.bought_type, bus.bought_valid, bus.deny);
            errors++;
        end
        step(2'b00, 1'b1, 2'd0, 1'b0);
        checks++;
        if (bus.deny !== 1'b1 || bus.bought_valid !== 1'b0 || bus.money_left !== 4'd0 || bus.bought_type !== 2'd3) begin
            $display("FAIL buy_deny: deny=%b bv=%b money=%0d type=%0d, required 1 0 0 3",
                     bus.deny, bus.bought_valid, bus.money_left, bus.bought_type);
            errors++;
        end
        step(2'b00, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.deny !== 1'b0) begin
            $display("FAIL deny_pulse: deny=%b, required 0", bus.deny);
            errors++;
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 7; i++) step(2'b10, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd14) begin
            $display("FAIL sat_pre: money=%0d, required 14", bus.money_left);
            errors++;
        end
        step(2'b11, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd15 || bus.coin_reject !== 1'b1) begin
            $display("FAIL sat_clip: money=%0d rej=%b, required 15 1", bus.money_left, bus.coin_reject);
            errors++;
        end
        step(2'b00, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd15 || bus.coin_reject !== 1'b0) begin
            $display("FAIL sat_pulse: money=%0d rej=%b, required 15 0", bus.money_left, bus.coin_reject);
            errors++;
        end
    endtask

    task automatic test_same_cycle();
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 2'd3, 1'b0);
        step(2'b01, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd1) begin
            $display("FAIL same_pre: money=%0d, required 1", bus.money_left);
            errors++;
        end
        step(2'b10, 1'b1, 2'd1, 1'b0);
        checks++;
        if (bus.deny !== 1'b1 || bus.money_left !== 4'd3 || bus.bought_valid !== 1'b0) begin
            $display("FAIL same_cycle: deny=%b money=%0d bv=%b, required 1 3 0",
                     bus.deny, bus.money_left, bus.bought_valid);
            errors++;
        end
    endtask

    task automatic test_refund();
        logic [3:0] exp_m  [3] = '{4'd2, 4'd1, 4'd0};
        logic       exp_cv [3] = '{1'b1, 1'b1, 1'b0};
        bus.change_ready = 1'b0;
        step(2'b00, 1'b0, 2'd0, 1'b1);
        checks++;
        if (bus.change_valid !== 1'b1 || bus.money_left !== 4'd3) begin
            $display("FAIL refund_enter: cv=%b money=%0d, required 1 3", bus.change_valid, bus.money_left);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            step((i == 1) ? 2'b01 : 2'b00, (i == 2), 2'd0, (i == 3));
            checks++;
            if (bus.change_valid !== 1'b1 || bus.money_left !== 4'd3 ||
                bus.coin_reject !== (i == 1) || bus.deny !== (i == 2)) begin
                $display("FAIL refund_hold[%0d]: cv=%b money=%0d rej=%b deny=%b, required 1 3 %0d %0d",
                         i, bus.change_valid, bus.money_left, bus.coin_reject, bus.deny, (i == 1), (i == 2));
                errors++;
            end
        end
        bus.change_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1'b0, 2'd0, 1'b0);
            checks++;
            if (bus.money_left !== exp_m[i] || bus.change_valid !== exp_cv[i]) begin
                $display("FAIL refund_accept[%0d]: money=%0d cv=%b, required %0d %b",
                         i, bus.money_left, bus.change_valid, exp_m[i], exp_cv[i]);
                errors++;
            end
        end
        step(2'b01, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd1 || bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0) begin
            $display("FAIL refund_exit: money=%0d rej=%b cv=%b, required 1 0 0",
                     bus.money_left, bus.coin_reject, bus.change_valid);
            errors++;
        end
    endtask

    task automatic test_refund_zero();
        step(2'b00, 1'b1, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd0 || bus.bought_valid !== 1'b1 || bus.bought_type !== 2'd0) begin
            $display("FAIL zero_pre: money=%0d bv=%b type=%0d, required 0 1 0",
                     bus.money_left, bus.bought_valid, bus.bought_type);
            errors++;
        end
        step(2'b00, 1'b0, 2'd0, 1'b1);
        checks++;
        if (bus.change_valid !== 1'b0 || bus.bought_valid !== 1'b0) begin
            $display("FAIL zero_enter: cv=%b bv=%b, required 0 0", bus.change_valid, bus.bought_valid);
            errors++;
        end
        step(2'b00, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.change_valid !== 1'b0) begin
            $display("FAIL zero_leave: cv=%b, required 0", bus.change_valid);
            errors++;
        end
        step(2'b01, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd1 || bus.coin_reject !== 1'b0) begin
            $display("FAIL zero_idle: money=%0d rej=%b, required 1 0", bus.money_left, bus.coin_reject);
            errors++;
        end
    endtask

    task automatic test_reset_mid_refund();
        step(2'b11, 1'b0, 2'd0, 1'b0);
        step(2'b11, 1'b0, 2'd0, 1'b0);
        step(2'b00, 1'b1, 2'd2, 1'b0);
        checks++;
        if (bus.money_left !== 4'd4 || bus.bought_type !== 2'd2 || bus.bought_valid !== 1'b1) begin
            $display("FAIL mid_pre: money=%0d type=%0d bv=%b, required 4 2 1",
                     bus.money_left, bus.bought_type, bus.bought_valid);
            errors++;
        end
        bus.change_ready = 1'b0;
        step(2'b00, 1'b0, 2'd0, 1'b1);
        bus.change_ready = 1'b1;
        step(2'b01, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd3 || bus.change_valid !== 1'b1 || bus.coin_reject !== 1'b1) begin
            $display("FAIL mid_accept: money=%0d cv=%b rej=%b, required 3 1 1",
                     bus.money_left, bus.change_valid, bus.coin_reject);
            errors++;
        end
        bus.change_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.money_left !== 4'd0 || bus.bought_type !== 2'd0 || bus.bought_valid !== 1'b0 ||
            bus.deny !== 1'b0 || bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0) begin
            $display("FAIL mid_reset: money=%0d type=%0d bv=%b deny=%b rej=%b cv=%b, required all zero",
                     bus.money_left, bus.bought_type, bus.bought_valid, bus.deny, bus.coin_reject, bus.change_valid);
            errors++;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(2'b01, 1'b0, 2'd0, 1'b0);
        checks++;
        if (bus.money_left !== 4'd1 || bus.coin_reject !== 1'b0 || bus.change_valid !== 1'b0) begin
            $display("FAIL mid_after: money=%0d rej=%b cv=%b, required 1 0 0",
                     bus.money_left, bus.coin_reject, bus.change_valid);
            errors++;
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.coin         = 2'b00;
        bus.buy          = 1'b0;
        bus.buy_type     = 2'd0;
        bus.clr          = 1'b0;
        bus.change_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_coins();
        test_buy();
        test_saturation();
        test_same_cycle();
        test_refund();
        test_refund_zero();
        test_reset_mid_refund();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_param.md
Name: vend_ctrl_param

Overview:
Parametrised successor to the vending coin counter. It accepts N coin types and M item types, each with its own configurable value and price. Credit saturates at MONEY_W bits, and a purchase is granted only when credit covers the price. Refunds are paid out one unit per handshake rather than cleared instantly. It sits between the per-button pulse filters and the LED/RGB display logic, and the pulse-filter outputs feed it directly.

Parameters:
NUM_COINS, 2, number of coin inputs (≥1)
NUM_ITEMS, 4, number of selectable items (≥2)
MONEY_W, 4, credit width; max credit 2^MONEY_W-1
COIN_VAL, {4'd2,4'd1}, packed NUM_COINS*MONEY_W; coin i value = COIN_VAL[i*MONEY_W +: MONEY_W]
ITEM_PRICE, {4'd5,4'd3,4'd2,4'd1}, packed NUM_ITEMS*MONEY_W; item j price = ITEM_PRICE[j*MONEY_W +: MONEY_W]

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
coin  in  NUM_COINS  one-cycle pulse per inserted coin; bits may assert simultaneously
buy  in  1  one-cycle purchase request pulse
buy_type  in  clog2(NUM_ITEMS)  item select, sampled on buy
clr  in  1  one-cycle refund request pulse
money_left  out  MONEY_W  current credit, registered
bought_type  out  clog2(NUM_ITEMS)  last granted item
bought_valid  out  1  level; high after a grant until the next buy, clr or reset
deny  out  1  one-cycle pulse: buy refused (insufficient credit or out-of-range type)
coin_reject  out  1  one-cycle pulse: coin value lost to saturation, or coin arriving during REFUND
change_valid  out  1  one unit of change is offered
change_ready  in  1  dispenser accepts offered unit

Behaviour:
- Reset: money_left=0, bought_type=0, bought_valid=0, deny=0, coin_reject=0, change_valid=0, state=IDLE.
- All outputs are registered. Effects appear on the cycle after the input edge.
- States: IDLE, REFUND.
- IDLE priority per cycle is clr > buy. Coins are always summed in the same cycle.
  - csum = sum of values of asserted coin bits, computed at MONEY_W+clog2(NUM_COINS) bits.
  - clr: refund amount = sat(money_left + csum). Go to REFUND, bought_valid←0, buy ignored.
  - buy with buy_type < NUM_ITEMS and money_left ≥ price: money_left ← sat(money_left − price + csum), bought_type←buy_type, bought_valid←1.
  - buy refused: deny←1, bought_valid←0, money_left ← sat(money_left + csum).
  - The buy check uses the registered credit only. Coins arriving in the same cycle do not fund that buy.
  - sat(x) = min(x, 2^MONEY_W−1). If clipping occurs, coin_reject←1.
- REFUND:
  - change_valid=1 while money_left>0.
  - Each cycle with change_valid&&change_ready decrements money_left by 1.
  - When money_left reaches 0 (the cycle after the last accept), change_valid←0 and state→IDLE.
  - If REFUND is entered with 0 credit, return to IDLE next cycle with change_valid never asserted.
  - coin pulses: coin_reject←1, credit unchanged.
  - buy: deny←1.
  - clr: ignored.
  - change_valid stays asserted while change_ready is low. It never drops without an accept.
- Reset mid-REFUND: immediate return to reset values. Undispensed change is discarded.

Decomposition:
- Package vend_pkg holds:
  - state enum {IDLE, REFUND}
  - default COIN_VAL and ITEM_PRICE constants
  - function sat_add(a, b, MONEY_W), returning the saturated value and a clip flag
- One sub-module, vend_coin_sum: combinational, parametrised on NUM_COINS and MONEY_W. It produces csum from coin and COIN_VAL.
- Target RTL size: ~180 lines total.

Test Plan:
- Reset, then coin=01 ×3 and coin=10 ×1 → money_left 1,2,3,5; no deny or reject.
- Credit 5, buy_type=3 (price 5) → money_left 0, bought_type 3, bought_valid 1. Then buy_type=0 → deny pulse, bought_valid 0.
- Credit 14, coin=11 (sum 3) → money_left 15, coin_reject pulse for one cycle.
- Credit 1, coin=10 and buy_type=1 (price 2) in the same cycle → deny, money_left 3.
- Credit 3, clr, change_ready held low 4 cycles then high → change_valid held, then exactly 3 accepts, money_left 3→0, IDLE. A coin during REFUND → coin_reject, credit unaffected.
- Credit 4, REFUND, rst asserted after 1 accept → all outputs at reset values on the same edge; state IDLE after rst drops.
